// File: rtl/puf_comp_pkg.sv
// Shared types and defaults for the PUF multi-pair counter comparator.
// Optional majority voting is enabled with the PUF_COMP_MAJ_EN macro.
package puf_comp_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int NPAIR_DEF    = 8;
    localparam int MARGIN_W_DEF = 16;

    localparam logic MODE_GT = 1'b0;
    localparam logic MODE_GE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/puf_comp_array_if.sv
// Request/result bundle between the RO counter bank and the comparator.
// Adds maj_rounds when PUF_COMP_MAJ_EN is defined.
interface puf_comp_array_if #(
    parameter int WIDTH    = 32,
    parameter int NPAIR    = 8,
    parameter int MARGIN_W = 16,
    parameter int CNT_W    = $clog2(NPAIR + 1)
);
    // start is a one-cycle request honoured only while busy=0 (extra pulses are
    // dropped, never queued); busy is high from the next cycle until done, and
    // done pulses for one cycle as resp/rel_mask/unrel_cnt take their new values.
    logic                      start;
    logic [NPAIR*WIDTH-1:0]    cnt_a;
    logic [NPAIR*WIDTH-1:0]    cnt_b;
    logic                      mode;
    logic [MARGIN_W-1:0]       margin;
`ifdef PUF_COMP_MAJ_EN
    logic [3:0]                maj_rounds;
`endif
    logic                      busy;
    logic                      done;
    logic [NPAIR-1:0]          resp;
    logic [NPAIR-1:0]          rel_mask;
    logic [CNT_W-1:0]          unrel_cnt;

`ifdef PUF_COMP_MAJ_EN
    modport master (
        output start, cnt_a, cnt_b, mode, margin, maj_rounds,
        input  busy, done, resp, rel_mask, unrel_cnt
    );
    modport slave (
        input  start, cnt_a, cnt_b, mode, margin, maj_rounds,
        output busy, done, resp, rel_mask, unrel_cnt
    );
`else
    modport master (
        output start, cnt_a, cnt_b, mode, margin,
        input  busy, done, resp, rel_mask, unrel_cnt
    );
    modport slave (
        input  start, cnt_a, cnt_b, mode, margin,
        output busy, done, resp, rel_mask, unrel_cnt
    );
`endif

endinterface

// File: rtl/puf_pair_cmp.sv
// Combinational compare of one count pair: response bit, reliability bit and
// absolute difference. Unsigned arithmetic throughout.
module puf_pair_cmp
    import puf_comp_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MARGIN_W = MARGIN_W_DEF
) (
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic                mode_i,
    input  logic [MARGIN_W-1:0] margin_i,
    output logic                resp_bit_o,
    output logic                rel_bit_o,
    output logic [WIDTH-1:0]    diff_o
);

    // Subtracting the smaller from the larger keeps diff within WIDTH bits.
    always_comb begin
        diff_o     = (a_i > b_i) ? (a_i - b_i) : (b_i - a_i);
        resp_bit_o = (mode_i == MODE_GE) ? (a_i >= b_i) : (a_i > b_i);
        rel_bit_o  = (diff_o > WIDTH'(margin_i));
    end

endmodule

// File: rtl/puf_comp_array.sv
// Multi-pair PUF comparator: shadows NPAIR count pairs, compares one per cycle
// and publishes response, reliability mask and unreliable count together.
// Define PUF_COMP_MAJ_EN for multi-round majority voting via maj_rounds.
module puf_comp_array
    import puf_comp_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NPAIR    = NPAIR_DEF,
    parameter int MARGIN_W = MARGIN_W_DEF,
    parameter int CNT_W    = $clog2(NPAIR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    puf_comp_array_if.slave  io,
    output state_e           state_o,
    output logic [WIDTH-1:0] diff_o
);

    localparam int IDX_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAIR - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NPAIR*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [NPAIR*WIDTH-1:0] b_sh_q, b_sh_d;
    logic                   mode_q, mode_d;
    logic [MARGIN_W-1:0]    margin_q, margin_d;
    logic [NPAIR-1:0]       rel_work_q, rel_work_d;
    logic [NPAIR-1:0]       resp_q, resp_d;
    logic [NPAIR-1:0]       rel_q, rel_d;
    logic [CNT_W-1:0]       unrel_q, unrel_d;
    logic                   done_q, done_d;
`ifdef PUF_COMP_MAJ_EN
    logic [NPAIR-1:0][3:0]  votes_q, votes_d;
    logic [3:0]             round_q, round_d;
    logic [3:0]             rounds_q, rounds_d;
`else
    logic [NPAIR-1:0]       resp_work_q, resp_work_d;
    logic [CNT_W-1:0]       unrel_work_q, unrel_work_d;
`endif

    logic [WIDTH-1:0] pair_a;
    logic [WIDTH-1:0] pair_b;
    logic             pair_resp;
    logic             pair_rel;

    assign pair_a = a_sh_q[int'(idx_q)*WIDTH +: WIDTH];
    assign pair_b = b_sh_q[int'(idx_q)*WIDTH +: WIDTH];

    puf_pair_cmp #(
        .WIDTH    (WIDTH),
        .MARGIN_W (MARGIN_W)
    ) u_pair_cmp (
        .a_i        (pair_a),
        .b_i        (pair_b),
        .mode_i     (mode_q),
        .margin_i   (margin_q),
        .resp_bit_o (pair_resp),
        .rel_bit_o  (pair_rel),
        .diff_o     (diff_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            mode_q       <= 1'b0;
            margin_q     <= '0;
            rel_work_q   <= '0;
            resp_q       <= '0;
            rel_q        <= '0;
            unrel_q      <= '0;
            done_q       <= 1'b0;
`ifdef PUF_COMP_MAJ_EN
            votes_q      <= '0;
            round_q      <= '0;
            rounds_q     <= '0;
`else
            resp_work_q  <= '0;
            unrel_work_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            mode_q       <= mode_d;
            margin_q     <= margin_d;
            rel_work_q   <= rel_work_d;
            resp_q       <= resp_d;
            rel_q        <= rel_d;
            unrel_q      <= unrel_d;
            done_q       <= done_d;
`ifdef PUF_COMP_MAJ_EN
            votes_q      <= votes_d;
            round_q      <= round_d;
            rounds_q     <= rounds_d;
`else
            resp_work_q  <= resp_work_d;
            unrel_work_q <= unrel_work_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        mode_d       = mode_q;
        margin_d     = margin_q;
        rel_work_d   = rel_work_q;
        resp_d       = resp_q;
        rel_d        = rel_q;
        unrel_d      = unrel_q;
        done_d       = 1'b0;
`ifdef PUF_COMP_MAJ_EN
        votes_d      = votes_q;
        round_d      = round_q;
        rounds_d     = rounds_q;
`else
        resp_work_d  = resp_work_q;
        unrel_work_d = unrel_work_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (io.start) state_d = LOAD;
            end

            LOAD: begin
                a_sh_d = io.cnt_a;
                b_sh_d = io.cnt_b;
                idx_d  = '0;
                state_d = CMP;
`ifdef PUF_COMP_MAJ_EN
                // Mode, margin and round count are fixed by the first round only.
                if (round_q == 4'd0) begin
                    mode_d     = io.mode;
                    margin_d   = io.margin;
                    rounds_d   = (io.maj_rounds == 4'd0) ? 4'd1 : io.maj_rounds;
                    votes_d    = '0;
                    rel_work_d = '1;
                end
`else
                mode_d       = io.mode;
                margin_d     = io.margin;
                resp_work_d  = '0;
                rel_work_d   = '0;
                unrel_work_d = '0;
`endif
            end

            CMP: begin
                idx_d = idx_q + IDX_W'(1);
`ifdef PUF_COMP_MAJ_EN
                rel_work_d[idx_q] = rel_work_q[idx_q] & pair_rel;
                if (pair_resp && (votes_q[idx_q] != 4'hF)) begin
                    votes_d[idx_q] = votes_q[idx_q] + 4'd1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if ((round_q + 4'd1) >= rounds_q) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        unrel_d = '0;
                        // Reliable only if reliable every round and the vote was unanimous.
                        for (int i = 0; i < NPAIR; i++) begin
                            resp_d[i] = ({1'b0, votes_d[i]} << 1) > {1'b0, rounds_q};
                            rel_d[i]  = rel_work_d[i] &
                                        ((votes_d[i] == 4'd0) || (votes_d[i] == rounds_q));
                            if (!rel_d[i]) unrel_d = unrel_d + CNT_W'(1);
                        end
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = LOAD;
                    end
                end
`else
                resp_work_d[idx_q] = pair_resp;
                rel_work_d[idx_q]  = pair_rel;
                if (!pair_rel) unrel_work_d = unrel_work_q + CNT_W'(1);
                // Outputs are loaded on entry to FIN so done and the new results coincide.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = FIN;
                    done_d  = 1'b1;
                    resp_d  = resp_work_d;
                    rel_d   = rel_work_d;
                    unrel_d = unrel_work_d;
                end
`endif
            end

            FIN: begin
                state_d = IDLE;
`ifdef PUF_COMP_MAJ_EN
                round_d = '0;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    assign io.busy      = (state_q != IDLE);
    assign io.done      = done_q;
    assign io.resp      = resp_q;
    assign io.rel_mask  = rel_q;
    assign io.unrel_cnt = unrel_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_puf_comp_array.sv
// Randomised scoreboard bench for puf_comp_array with directed corner pairs,
// mid-operation reset, ignored restarts and input scrambling after LOAD.
module tb_puf_comp_array;
    import puf_comp_pkg::*;

    localparam int WIDTH    = 32;
    localparam int NPAIR    = 8;
    localparam int MARGIN_W = 16;
    localparam int CNT_W    = $clog2(NPAIR + 1);
    localparam int NW       = NPAIR * WIDTH;
    localparam int EW       = 2 * NPAIR + CNT_W;
    localparam int BUDGET   = 4 * NPAIR + 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    puf_comp_array_if #(.WIDTH(WIDTH), .NPAIR(NPAIR), .MARGIN_W(MARGIN_W), .CNT_W(CNT_W)) io ();
    state_e           dbg_state;
    logic [WIDTH-1:0] dbg_diff;

    puf_comp_array #(.WIDTH(WIDTH), .NPAIR(NPAIR), .MARGIN_W(MARGIN_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (io),
        .state_o (dbg_state),
        .diff_o  (dbg_diff)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: signed 64-bit arithmetic on each pair, straight from the rules.
    function automatic logic [EW-1:0] model(input logic [NW-1:0] av, input logic [NW-1:0] bv,
                                            input logic md, input logic [MARGIN_W-1:0] mg);
        logic [NPAIR-1:0] r;
        logic [NPAIR-1:0] rl;
        int               unrel;
        longint           a, b, d;
        unrel = 0;
        for (int i = 0; i < NPAIR; i++) begin
            a = av[i*WIDTH +: WIDTH];
            b = bv[i*WIDTH +: WIDTH];
            d = a - b;
            if (d < 0) d = -d;
            r[i]  = md ? (a >= b) : (a > b);
            rl[i] = (d > longint'(mg));
            if (!rl[i]) unrel++;
        end
        return {r, rl, CNT_W'(unrel)};
    endfunction

    task automatic gen_pairs(output logic [NW-1:0] av, output logic [NW-1:0] bv);
        logic [WIDTH-1:0] x, y, t;
        for (int i = 0; i < NPAIR; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x + WIDTH'($urandom_range(0, 20)) - WIDTH'(10);
                2:       y = $urandom;
                default: begin x = '1; y = '0; end
            endcase
            if ($urandom_range(0, 1) == 1) begin t = x; x = y; y = t; end
            av[i*WIDTH +: WIDTH] = x;
            bv[i*WIDTH +: WIDTH] = y;
        end
    endtask

    function automatic logic [MARGIN_W-1:0] gen_margin();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return MARGIN_W'($urandom_range(0, 20));
            2:       return '1;
            default: return MARGIN_W'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && io.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("resp", io.resp, e[EW-1 -: NPAIR]);
                chk("rel_mask", io.rel_mask, e[CNT_W +: NPAIR]);
                chk("unrel_cnt", io.unrel_cnt, e[CNT_W-1:0]);
            end
        end
    end

    task automatic run_op(input logic [NW-1:0] av, input logic [NW-1:0] bv, input logic md,
                          input logic [MARGIN_W-1:0] mg, input bit scramble, input bit restart);
        logic [EW-1:0] prev;
        bit            held;
        bit            got;
        int            n;
        @(negedge clk);
        io.cnt_a = av; io.cnt_b = bv; io.mode = md; io.margin = mg; io.start = 1'b1;
        exp_q.push_back(model(av, bv, md, mg));
        prev = {io.resp, io.rel_mask, io.unrel_cnt};
        held = 1'b1; got = 1'b0; n = 0;
        while (!got && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            io.start = (restart && n == 3);
            if (n == 1) chk("busy_after_start", io.busy, 1);
            if (scramble && n >= 2) begin
                io.cnt_a = {NPAIR{$urandom}}; io.cnt_b = {NPAIR{$urandom}};
                io.mode = ~io.mode; io.margin = MARGIN_W'($urandom);
            end
            if (io.done) got = 1'b1;
            else if ({io.resp, io.rel_mask, io.unrel_cnt} !== prev) held = 1'b0;
        end
        io.start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        else begin
            chk("latency", n, NPAIR + 2);
            chk("outputs_held", held, 1);
            @(posedge clk); @(negedge clk);
            chk("idle_after_done", io.busy, 0);
        end
    endtask

    logic [NW-1:0] dir_a, dir_b, ra, rb;

    initial begin
        rst = 1'b1; io.start = 1'b0; io.cnt_a = '0; io.cnt_b = '0; io.mode = 1'b0; io.margin = '0;
`ifdef PUF_COMP_MAJ_EN
        io.maj_rounds = 4'd1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", io.busy, 0);
        chk("rst_done", io.done, 0);
        chk("rst_resp", io.resp, 0);
        chk("rst_rel", io.rel_mask, 0);
        chk("rst_unrel", io.unrel_cnt, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;

        gen_pairs(dir_a, dir_b);
        dir_a[0*WIDTH +: WIDTH] = 100;           dir_b[0*WIDTH +: WIDTH] = 50;
        dir_a[1*WIDTH +: WIDTH] = 77;            dir_b[1*WIDTH +: WIDTH] = 77;
        dir_a[2*WIDTH +: WIDTH] = 60;            dir_b[2*WIDTH +: WIDTH] = 50;
        dir_a[3*WIDTH +: WIDTH] = 32'hFFFF_FFFF; dir_b[3*WIDTH +: WIDTH] = 0;

        run_op(dir_a, dir_b, MODE_GT, 16'd10, 0, 0);
        chk("p0_resp", io.resp[0], 1);
        chk("p0_rel", io.rel_mask[0], 1);
        chk("p1_resp_gt", io.resp[1], 0);
        chk("p1_rel", io.rel_mask[1], 0);
        chk("p2_rel_m10", io.rel_mask[2], 0);
        chk("p3_resp", io.resp[3], 1);
        chk("p3_rel", io.rel_mask[3], 1);
        run_op(dir_a, dir_b, MODE_GE, 16'd10, 0, 0);
        chk("p1_resp_ge", io.resp[1], 1);
        run_op(dir_a, dir_b, MODE_GT, 16'd9, 0, 0);
        chk("p2_rel_m9", io.rel_mask[2], 1);
        run_op(dir_a, dir_b, MODE_GE, 16'hFFFF, 0, 1);
        chk("p3_rel_maxmargin", io.rel_mask[3], 1);

        // Reset in the middle of the compare sweep discards the operation.
        gen_pairs(ra, rb);
        @(negedge clk);
        io.cnt_a = ra; io.cnt_b = rb; io.start = 1'b1;
        @(posedge clk); @(negedge clk); io.start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_busy", io.busy, 0);
        chk("midrst_resp", io.resp, 0);
        chk("midrst_rel", io.rel_mask, 0);
        chk("midrst_unrel", io.unrel_cnt, 0);
        rst = 1'b0;

        gen_pairs(ra, rb);
        run_op(ra, rb, MODE_GT, gen_margin(), 0, 0);
        gen_pairs(ra, rb);
        run_op(ra, rb, MODE_GE, 16'd5, 1, 0);

        for (int k = 0; k < 20; k++) begin
            gen_pairs(ra, rb);
            run_op(ra, rb, 1'($urandom_range(0, 1)), gen_margin(),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
